// File: rtl/wfg_record_spi.sv
// SPI slave recorder: deserialises words from an external SPI master and streams them into a
// ring of SRAM word addresses through a small FIFO, one write per clock.
module wfg_record_spi #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 9
) (
    input  logic              io_wbs_clk,
    input  logic              io_wbs_rst_n,
    input  logic              cfg_en_i,
    input  logic              cfg_cpol_i,
    input  logic [1:0]        cfg_wordsize_i,
    input  logic [ADDR_W-1:0] cfg_start_addr_i,
    input  logic [ADDR_W-1:0] cfg_end_addr_i,
    input  logic              spi_sclk_i,
    input  logic              spi_cs_ni,
    input  logic              spi_sdi_i,
    output logic              csb_o,
    output logic              web_o,
    output logic [3:0]        wmask_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [31:0]       din_o,
    output logic              overflow_o,
    output logic [15:0]       word_cnt_o
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

    // ---------------------------------------------------------------- synchronizers
    logic [1:0] sclk_sync_q;
    logic       sclk_prev_q;
    logic [1:0] cs_sync_q;
    logic [1:0] sdi_sync_q;

    // Idle levels on reset so release never looks like an sclk edge or an open frame.
    always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
        if (!io_wbs_rst_n) begin
            sclk_sync_q <= {2{cfg_cpol_i}};
            sclk_prev_q <= cfg_cpol_i;
            cs_sync_q   <= 2'b11;
            sdi_sync_q  <= 2'b00;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], spi_sclk_i};
            sclk_prev_q <= sclk_sync_q[1];
            cs_sync_q   <= {cs_sync_q[0], spi_cs_ni};
            sdi_sync_q  <= {sdi_sync_q[0], spi_sdi_i};
        end
    end

    logic sclk_s, cs_n_s, sdi_s;
    logic sample_edge, capture_active, sample;

    assign sclk_s         = sclk_sync_q[1];
    assign cs_n_s         = cs_sync_q[1];
    assign sdi_s          = sdi_sync_q[1];
    assign sample_edge    = cfg_cpol_i ? (sclk_prev_q & ~sclk_s) : (sclk_s & ~sclk_prev_q);
    assign capture_active = cfg_en_i & ~cs_n_s;
    assign sample         = sample_edge & capture_active;

    // ---------------------------------------------------------------- deserialiser
    logic [4:0]  width_m1;
    logic [31:0] word_mask;
    logic [31:0] shifted;

    always_comb begin
        unique case (cfg_wordsize_i)
            2'd0:    width_m1 = 5'd7;
            2'd1:    width_m1 = 5'd15;
            2'd2:    width_m1 = 5'd23;
            default: width_m1 = 5'd31;
        endcase
    end

    assign word_mask = 32'hFFFF_FFFF >> (5'd31 - width_m1);

    logic [31:0] shift_q, shift_d;
    logic [4:0]  bitcnt_q, bitcnt_d;
    logic        push_vld_q, push_vld_d;
    logic [31:0] push_word_q, push_word_d;

    assign shifted = {shift_q[30:0], sdi_s};

    always_comb begin
        shift_d     = shift_q;
        bitcnt_d    = bitcnt_q;
        push_vld_d  = 1'b0;
        push_word_d = push_word_q;
        if (!capture_active) begin
            // Disable or a closed frame discards any partial word.
            shift_d  = '0;
            bitcnt_d = '0;
        end else if (sample) begin
            if (bitcnt_q == width_m1) begin
                push_vld_d  = 1'b1;
                push_word_d = shifted & word_mask;
                shift_d     = '0;
                bitcnt_d    = '0;
            end else begin
                shift_d  = shifted;
                bitcnt_d = bitcnt_q + 5'd1;
            end
        end
    end

    always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
        if (!io_wbs_rst_n) begin
            shift_q     <= '0;
            bitcnt_q    <= '0;
            push_vld_q  <= 1'b0;
            push_word_q <= '0;
        end else begin
            shift_q     <= shift_d;
            bitcnt_q    <= bitcnt_d;
            push_vld_q  <= push_vld_d;
            push_word_q <= push_word_d;
        end
    end

    // ---------------------------------------------------------------- word FIFO
    logic [31:0]     fifo_mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_idx_q, rd_idx_q;
    logic [CntW-1:0] fifo_cnt_q;
    logic            fifo_full, fifo_empty;
    logic            drain_en;
    logic            push_req, push, pop, drop;

    assign fifo_full  = (fifo_cnt_q == DepthCnt);
    assign fifo_empty = (fifo_cnt_q == '0);
    assign drain_en   = cfg_en_i;
    assign pop        = drain_en & ~fifo_empty;
    assign push_req   = push_vld_q & cfg_en_i;
    // A full FIFO still accepts a word when an entry leaves in the same cycle.
    assign push       = push_req & (~fifo_full | pop);
    assign drop       = push_req & fifo_full & ~pop;

    always_ff @(posedge io_wbs_clk) begin
        if (push) begin
            fifo_mem_q[wr_idx_q] <= push_word_q;
        end
    end

    always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
        if (!io_wbs_rst_n) begin
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            fifo_cnt_q <= '0;
        end else if (!cfg_en_i) begin
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                wr_idx_q <= wr_idx_q + PtrW'(1);
            end
            if (pop) begin
                rd_idx_q <= rd_idx_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CntW'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CntW'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // ---------------------------------------------------------------- SRAM writer
    logic              csb_q, web_q;
    logic [3:0]        wmask_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       din_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              overflow_q;
    logic [15:0]       word_cnt_q;

    always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
        if (!io_wbs_rst_n) begin
            csb_q      <= 1'b1;
            web_q      <= 1'b1;
            wmask_q    <= '0;
            addr_q     <= '0;
            din_q      <= '0;
            ptr_q      <= '0;
            overflow_q <= 1'b0;
            word_cnt_q <= '0;
        end else if (!cfg_en_i) begin
            csb_q      <= 1'b1;
            web_q      <= 1'b1;
            ptr_q      <= cfg_start_addr_i;
            overflow_q <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            csb_q <= ~pop;
            web_q <= ~pop;
            if (pop) begin
                wmask_q <= 4'hF;
                addr_q  <= ptr_q;
                din_q   <= fifo_mem_q[rd_idx_q];
                // Equality test also covers an end address below the start address.
                ptr_q   <= (ptr_q == cfg_end_addr_i) ? cfg_start_addr_i : ptr_q + ADDR_W'(1);
                if (word_cnt_q != 16'hFFFF) begin
                    word_cnt_q <= word_cnt_q + 16'd1;
                end
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign csb_o      = csb_q;
    assign web_o      = web_q;
    assign wmask_o    = wmask_q;
    assign addr_o     = addr_q;
    assign din_o      = din_q;
    assign overflow_o = overflow_q;
    assign word_cnt_o = word_cnt_q;

endmodule

// File: tb/tb_wfg_record_spi.sv
// Scoreboard bench for wfg_record_spi: expected SRAM writes are queued as words are sent and
// compared by a monitor whenever the DUT writes.
module tb_wfg_record_spi;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_en = 1'b0;
    logic        cfg_cpol = 1'b0;
    logic [1:0]  cfg_ws = 2'd0;
    logic [8:0]  cfg_start = 9'd0;
    logic [8:0]  cfg_end = 9'd0;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_sdi = 1'b0;
    logic        csb_o, web_o, overflow_o;
    logic [3:0]  wmask_o;
    logic [8:0]  addr_o;
    logic [31:0] din_o;
    logic [15:0] word_cnt_o;

    wfg_record_spi #(
        .FIFO_DEPTH(4),
        .ADDR_W    (9)
    ) dut (
        .io_wbs_clk      (clk),
        .io_wbs_rst_n    (rst_n),
        .cfg_en_i        (cfg_en),
        .cfg_cpol_i      (cfg_cpol),
        .cfg_wordsize_i  (cfg_ws),
        .cfg_start_addr_i(cfg_start),
        .cfg_end_addr_i  (cfg_end),
        .spi_sclk_i      (spi_sclk),
        .spi_cs_ni       (spi_cs_n),
        .spi_sdi_i       (spi_sdi),
        .csb_o           (csb_o),
        .web_o           (web_o),
        .wmask_o         (wmask_o),
        .addr_o          (addr_o),
        .din_o           (din_o),
        .overflow_o      (overflow_o),
        .word_cnt_o      (word_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_checks = 0;
    int  n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic exp_wr(input logic [8:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    always @(negedge clk) begin
        if (rst_n && csb_o === 1'b0) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_write", 32'(csb_o), 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("wr_addr", 32'(addr_o), 32'(mon_e.addr));
                check_val("wr_data", din_o, mon_e.data);
                check_val("wr_mask", 32'(wmask_o), 32'hF);
                check_val("wr_web", 32'(web_o), 32'd0);
            end
        end
    end

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Each sclk phase lasts 4 clocks; data changes on the non-sampling edge.
    task automatic spi_bits(input logic [31:0] w, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_sclk = cfg_cpol;
            spi_sdi  = w[i];
            clk_n(4);
            spi_sclk = ~cfg_cpol;
            clk_n(4);
        end
        spi_sclk = cfg_cpol;
    endtask

    task automatic frame_start();
        spi_cs_n = 1'b0;
        clk_n(4);
    endtask

    task automatic frame_end();
        clk_n(4);
        spi_cs_n = 1'b1;
        clk_n(4);
    endtask

    task automatic set_cfg(input logic cpol, input logic [1:0] ws, input logic [8:0] s,
                           input logic [8:0] e);
        cfg_en = 1'b0;
        clk_n(2);
        cfg_cpol  = cpol;
        cfg_ws    = ws;
        cfg_start = s;
        cfg_end   = e;
        spi_sclk  = cpol;
        spi_cs_n  = 1'b1;
        clk_n(4);
        cfg_en = 1'b1;
        clk_n(2);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) begin
            clk_n(1);
        end
        check_val(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        clk_n(6);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [31:0] words_c[4];
    logic [31:0] bytes_f[5];
    bit          seen;

    initial begin
        // Reset values while held in reset.
        clk_n(3);
        check_val("rst_csb", 32'(csb_o), 32'd1);
        check_val("rst_web", 32'(web_o), 32'd1);
        check_val("rst_wmask", 32'(wmask_o), 32'd0);
        check_val("rst_addr", 32'(addr_o), 32'd0);
        check_val("rst_din", din_o, 32'd0);
        check_val("rst_ovf", 32'(overflow_o), 32'd0);
        check_val("rst_cnt", 32'(word_cnt_o), 32'd0);
        rst_n = 1'b1;
        clk_n(2);

        // Mode 0, 8-bit word.
        set_cfg(1'b0, 2'd0, 9'h010, 9'h01F);
        exp_wr(9'h010, 32'h0000_00A5);
        frame_start();
        spi_bits(32'hA5, 8);
        frame_end();
        wait_drain("drain_a5");
        check_val("a5_cnt", 32'(word_cnt_o), 32'd1);
        check_val("a5_ovf", 32'(overflow_o), 32'd0);

        // CPOL=1, two 32-bit words in one frame.
        set_cfg(1'b1, 2'd3, 9'h040, 9'h05F);
        exp_wr(9'h040, 32'hDEAD_BEEF);
        exp_wr(9'h041, 32'h0123_4567);
        frame_start();
        spi_bits(32'hDEAD_BEEF, 32);
        spi_bits(32'h0123_4567, 32);
        frame_end();
        wait_drain("drain_w32");
        check_val("w32_cnt", 32'(word_cnt_o), 32'd2);
        check_val("w32_ovf", 32'(overflow_o), 32'd0);

        // 24-bit words, zero-extended.
        set_cfg(1'b0, 2'd2, 9'h000, 9'h0FF);
        exp_wr(9'h000, 32'h00C3_5A81);
        frame_start();
        spi_bits(32'h00C3_5A81, 24);
        frame_end();
        wait_drain("drain_w24");

        // Two-entry ring at the top of the address space.
        set_cfg(1'b0, 2'd1, 9'h1FE, 9'h1FF);
        words_c = '{32'h1111, 32'hF00D, 32'h8000, 32'h0001};
        for (int i = 0; i < 4; i++) begin
            exp_wr((i % 2 == 0) ? 9'h1FE : 9'h1FF, words_c[i]);
        end
        frame_start();
        for (int i = 0; i < 4; i++) begin
            spi_bits(words_c[i], 16);
        end
        frame_end();
        wait_drain("drain_ring");
        check_val("ring_cnt", 32'(word_cnt_o), 32'd4);

        // End below start: pointer wraps through zero.
        set_cfg(1'b0, 2'd0, 9'h1FF, 9'h001);
        exp_wr(9'h1FF, 32'h11);
        exp_wr(9'h000, 32'h22);
        exp_wr(9'h001, 32'h33);
        exp_wr(9'h1FF, 32'h44);
        frame_start();
        spi_bits(32'h11, 8);
        spi_bits(32'h22, 8);
        spi_bits(32'h33, 8);
        spi_bits(32'h44, 8);
        frame_end();
        wait_drain("drain_wrap");

        // Partial word discarded by cs_n rising.
        set_cfg(1'b0, 2'd1, 9'h020, 9'h02F);
        frame_start();
        spi_bits(32'h1F, 5);
        frame_end();
        exp_wr(9'h020, 32'h0000_8001);
        frame_start();
        spi_bits(32'h8001, 16);
        frame_end();
        wait_drain("drain_partial");
        check_val("partial_cnt", 32'(word_cnt_o), 32'd1);

        // Overflow: drain stalled, five words into a four-entry FIFO.
        set_cfg(1'b0, 2'd0, 9'h080, 9'h08F);
        bytes_f = '{32'h01, 32'h02, 32'h03, 32'h04, 32'h05};
        force dut.drain_en = 1'b0;
        frame_start();
        for (int i = 0; i < 5; i++) begin
            spi_bits(bytes_f[i], 8);
        end
        frame_end();
        check_val("ovf_set", 32'(overflow_o), 32'd1);
        check_val("ovf_stall_cnt", 32'(word_cnt_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            exp_wr(9'h080 + 9'(i), bytes_f[i]);
        end
        release dut.drain_en;
        wait_drain("drain_ovf");
        check_val("ovf_sticky", 32'(overflow_o), 32'd1);
        check_val("ovf_cnt", 32'(word_cnt_o), 32'd4);
        cfg_en = 1'b0;
        clk_n(2);
        check_val("ovf_clear", 32'(overflow_o), 32'd0);
        check_val("cnt_clear", 32'(word_cnt_o), 32'd0);

        // Reset asserted in the cycle a write is presented.
        set_cfg(1'b0, 2'd0, 9'h030, 9'h03F);
        frame_start();
        spi_bits(32'h5A, 8);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (csb_o === 1'b0) begin
                seen = 1'b1;
            end else begin
                clk_n(1);
            end
        end
        check_val("pre_rst_csb", 32'(csb_o), 32'd0);
        check_val("pre_rst_addr", 32'(addr_o), 32'h030);
        check_val("pre_rst_din", din_o, 32'h5A);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_csb", 32'(csb_o), 32'd1);
        check_val("mid_rst_web", 32'(web_o), 32'd1);
        check_val("mid_rst_wmask", 32'(wmask_o), 32'd0);
        check_val("mid_rst_addr", 32'(addr_o), 32'd0);
        check_val("mid_rst_din", din_o, 32'd0);
        check_val("mid_rst_cnt", 32'(word_cnt_o), 32'd0);
        cfg_en   = 1'b0;
        spi_cs_n = 1'b1;
        clk_n(3);
        rst_n = 1'b1;
        clk_n(2);

        // Fresh word after reset release.
        set_cfg(1'b0, 2'd0, 9'h030, 9'h03F);
        exp_wr(9'h030, 32'h3C);
        frame_start();
        spi_bits(32'h3C, 8);
        frame_end();
        wait_drain("drain_post_rst");
        check_val("post_rst_cnt", 32'(word_cnt_o), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wfg_record_spi.md
WFG_RECORD_SPI -- requirements
Module: wfg_record_spi

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, number of captured-word buffer entries (power of two, at least 2).
REQ-002 Parameter: ADDR_W, default 9, SRAM word-address width.
REQ-003 io_wbs_clk  in  1  sole clock, all state on its rising edge.
REQ-004 io_wbs_rst_n  in  1  asynchronous active-low reset.
REQ-005 cfg_en_i  in  1  capture enable; low = idle and flush.
REQ-006 cfg_cpol_i  in  1  SPI clock polarity (0 = sample on sclk rise, 1 = sample on sclk fall).
REQ-007 cfg_wordsize_i  in  2  word width: 0 = 8, 1 = 16, 2 = 24, 3 = 32 bits.
REQ-008 cfg_start_addr_i  in  ADDR_W  first SRAM word address of the ring.
REQ-009 cfg_end_addr_i  in  ADDR_W  last SRAM word address of the ring, inclusive.
REQ-010 spi_sclk_i  in  1  external SPI clock, asynchronous.
REQ-011 spi_cs_ni  in  1  external chip select, active low, asynchronous.
REQ-012 spi_sdi_i  in  1  external serial data, MSB first, asynchronous.
REQ-013 csb_o  out  1  SRAM port-0 chip select, active low.
REQ-014 web_o  out  1  SRAM port-0 write enable, active low.
REQ-015 wmask_o  out  4  SRAM byte write mask.
REQ-016 addr_o  out  ADDR_W  SRAM word address.
REQ-017 din_o  out  32  SRAM write data.
REQ-018 overflow_o  out  1  sticky flag: a completed word was dropped.
REQ-019 word_cnt_o  out  16  count of words written to SRAM since enable (saturates at 16'hFFFF).

Function
REQ-020 spi_sclk_i, spi_cs_ni and spi_sdi_i shall each pass through a 2-flop synchronizer; sclk edges shall be detected from the synchronized value and one further register stage.
REQ-021 The sample edge shall be the synchronized sclk rise when cfg_cpol_i=0 and the synchronized sclk fall when cfg_cpol_i=1; synchronized sdi shall be sampled on the same clock as the edge is detected.
REQ-022 The bench-guaranteed operating limit is: each sclk high and low phase lasts at least 3 io_wbs_clk periods.
REQ-023 Bits shall be shifted into a 32-bit register only while cfg_en_i=1 and synchronized cs_n=0; the first bit received is the MSB of the word.
REQ-024 The bit counter shall count from 0 to W-1, where W is the width selected by cfg_wordsize_i. On the W-th sample the word shall be complete, zero-extended to 32 bits in the LSBs, and the counter shall return to 0.
REQ-025 A completed word shall be pushed into the FIFO on the clock after the W-th sample.
REQ-026 If the FIFO is full when a word is pushed, the word shall be dropped, the FIFO contents left unchanged, and overflow_o set to 1.
REQ-027 Synchronized cs_n going high shall discard any partial word and clear the bit counter. Words already completed shall be retained.
REQ-028 The writer shall pop one FIFO entry per clock whenever the FIFO is non-empty and cfg_en_i=1. For each pop, on the next clock it shall register csb_o=0, web_o=0, wmask_o=4'hF, addr_o=write pointer, din_o=popped word, each held for exactly 1 cycle.
REQ-029 On cycles with no write, csb_o=1 and web_o=1; wmask_o, addr_o and din_o shall hold their last values.
REQ-030 After each write the pointer shall wrap to cfg_start_addr_i if it equals cfg_end_addr_i, and otherwise increment by 1. word_cnt_o shall increment by 1 with saturation.
REQ-031 A simultaneous push and pop on a full FIFO shall succeed with no overflow. A push to an empty FIFO shall be writable no earlier than the next clock.
REQ-032 If cfg_end_addr_i < cfg_start_addr_i, the pointer shall increment with ADDR_W-bit wrap-around until it equals cfg_end_addr_i.
REQ-033 While cfg_en_i=0, the block shall:
- flush the FIFO, bit counter and shift register;
- load the write pointer with cfg_start_addr_i;
- clear overflow_o and word_cnt_o;
- issue no writes.
REQ-034 A cfg_en_i fall during a word shall discard that word. A write already registered in the same cycle shall still complete.
REQ-035 Configuration inputs are static while cfg_en_i=1; changes to them while enabled produce undefined data but never an X on any output.

Reset
REQ-036 While io_wbs_rst_n=0, the block shall immediately force csb_o=1, web_o=1, wmask_o=0, addr_o=0, din_o=0, overflow_o=0 and word_cnt_o=0, and clear the FIFO, counters and synchronizers (sclk/cs_n synchronizers to their idle levels: cs_n=1, sclk=cfg_cpol_i).
REQ-037 Release of io_wbs_rst_n shall be synchronized externally. The first write shall need a complete new word after release. A reset asserted mid-word shall lose that word.

Verification
REQ-038 Mode 0, 8-bit word, start=0x010: send 0xA5 -> one write with addr_o=0x010, din_o=0x000000A5, wmask_o=4'hF; word_cnt_o=1.
REQ-039 32-bit word, CPOL=1, send 0xDEADBEEF then 0x01234567 in one cs_n frame -> writes at start and start+1 with those values; overflow_o=0.
REQ-040 Ring with start=0x1FE, end=0x1FF, four 16-bit words -> addresses 0x1FE, 0x1FF, 0x1FE, 0x1FF.
REQ-041 Hold cfg_en_i and FIFO drain path stalled via force (FIFO_DEPTH=4), push 5 words -> 4 retained, overflow_o=1; cfg_en_i low clears it.
REQ-042 Raise cs_n after 5 bits of a 16-bit word, then send 0x8001 -> single write din_o=0x00008001.
REQ-043 Assert io_wbs_rst_n low mid-write -> csb_o=1 and web_o=1 in the same cycle, all outputs at reset values.
